vr_stream_gen: RTL



---
 rtl/vr_stream_gen_pkg.sv | 14 +
 rtl/vr_stream_gen_lfsr8.sv | 23 ++
 rtl/vr_stream_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/vr_stream_gen_pkg.sv
// Shared types and constants for the vr_stream_gen valid/ready traffic source.
package vr_stream_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1, state shifting toward the MSB
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/vr_stream_gen_lfsr8.sv
// 8-bit Fibonacci LFSR used as the pseudo-random valid throttle of vr_stream_gen.
module lfsr8
  import vr_stream_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [7:0] state
);

  logic [7:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else if (enable) begin
      state_q <= {state_q[6:0], ^(state_q & LFSR_TAPS)};
    end
  end

  assign state = state_q;

endmodule

// File: rtl/vr_stream_gen.sv
// Valid/ready burst generator emitting incrementing data words.
// Optional pseudo-random valid throttle enabled by defining VR_STREAM_GEN_THROTTLE_EN.
module vr_stream_gen
  import vr_stream_gen_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 6,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  input  logic [D_WIDTH-1:0]   seed_data,
  output logic [D_WIDTH-1:0]   down_data,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic                 busy,
  output logic                 done
);

  state_t               state_q, state_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic [D_WIDTH-1:0]   data_q, data_n;
  logic                 valid_q, valid_n;
  logic                 busy_q, done_q;
  logic                 xfer;
  logic                 valid_gate;

`ifdef VR_STREAM_GEN_THROTTLE_EN
  logic [7:0] lfsr_state;

  lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (1'b1),
    .state  (lfsr_state)
  );

  assign valid_gate = lfsr_state[0];
`else
  assign valid_gate = 1'b1;
`endif

  assign xfer = valid_q & down_ready;

  // valid is only (re)evaluated when low or when a transfer retires the current word
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    valid_n = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_n = RUN;
            cnt_n   = num_words;
            data_n  = seed_data;
            valid_n = valid_gate;
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          data_n = data_q + D_WIDTH'(1);
          cnt_n  = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_n = DONE;
            valid_n = 1'b0;
          end else begin
            valid_n = valid_gate;
          end
        end else if (!valid_q) begin
          valid_n = valid_gate;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      busy_q  <= (state_n == RUN);
      done_q  <= (state_n == DONE);
    end
  end

  assign down_data  = data_q;
  assign down_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
